tile_kernel_acc: RTL and testbench

TILE_KERNEL_ACC -- requirements
Module: tile_kernel_acc

---
 rtl/tile_pkg.sv | 13 +
 rtl/tile_row_adder.sv | 19 +
 rtl/tile_kernel_acc.sv | 158 +++++++++++++++
 tb/tb_tile_kernel_acc.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared defaults and accumulator FSM encoding for the tile kernel accumulator.
package tile_pkg;
    localparam int TILE_M_BW = 16;
    localparam int TILE_ROWS = 5;
    localparam int TILE_COLS = 5;
    localparam int TILE_A_BW = 24;

    typedef logic [1:0] accum_state_t;

    localparam accum_state_t ACCUM_IDLE = 2'd0;
    localparam accum_state_t ACCUM_RUN  = 2'd1;
    localparam accum_state_t ACCUM_HOLD = 2'd2;
endpackage

// File: rtl/tile_row_adder.sv
// Combinational signed adder: sign-extends N packed IN_BW-bit terms and sums them to OUT_BW bits.
module tile_row_adder
    import tile_pkg::*;
#(
    parameter int IN_BW  = TILE_M_BW,
    parameter int N      = TILE_COLS,
    parameter int OUT_BW = TILE_M_BW + 3
) (
    input  logic [IN_BW*N-1:0]        terms,
    output logic signed [OUT_BW-1:0]  sum
);
    always_comb begin
        // NOTE: assigning a default before the loop keeps this purely combinational (no latch).
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum = sum + OUT_BW'($signed(terms[i*IN_BW +: IN_BW]));
        end
    end
endmodule

// File: rtl/tile_kernel_acc.sv
// Three-stage reduction of a ROWS x COLS tile of PE products into a per-window kernel sum.
// Define TILE_ACC_SAT_EN to saturate the accumulator (sticky o_overflow); otherwise it wraps.
module tile_kernel_acc
    import tile_pkg::*;
#(
    parameter int M_BW = TILE_M_BW,
    parameter int ROWS = TILE_ROWS,
    parameter int COLS = TILE_COLS,
    parameter int A_BW = TILE_A_BW
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_mul_valid,
    input  logic [M_BW*ROWS*COLS-1:0]   i_mul_result,
    input  logic                        i_last,
    input  logic                        i_clr,
    output logic                        o_ready,
    output logic                        o_acc_valid,
    input  logic                        i_acc_ready,
    output logic signed [A_BW-1:0]      os_acc_kernel,
    output logic                        o_overflow
);
    localparam int R_BW = M_BW + 3;
    localparam int S_BW = M_BW + 5;

    logic stall;
    logic beat_in;

    assign stall   = o_acc_valid && !i_acc_ready;
    assign o_ready = !stall;
    assign beat_in = i_mul_valid && o_ready && !i_clr;

    // Stage 1: per-row sums
    logic signed [R_BW-1:0] row_sum [ROWS];
    logic signed [R_BW-1:0] s1_row  [ROWS];
    logic                   s1_valid;
    logic                   s1_last;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        tile_row_adder #(
            .IN_BW  (M_BW),
            .N      (COLS),
            .OUT_BW (R_BW)
        ) u_row_adder (
            .terms (i_mul_result[M_BW*COLS*r +: M_BW*COLS]),
            .sum   (row_sum[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking updates so each stage captures its upstream's pre-edge value.
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            // NOTE: this array is a handful of flops, so it is reset like any register.
            for (int r = 0; r < ROWS; r++) s1_row[r] <= '0;
        end else if (i_clr) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else if (!stall) begin
            s1_valid <= beat_in;
            s1_last  <= beat_in && i_last;
            for (int r = 0; r < ROWS; r++) s1_row[r] <= row_sum[r];
        end
    end

    // Stage 2: tile sum
    logic signed [S_BW-1:0] s2_next;
    logic signed [S_BW-1:0] s2_sum;
    logic                   s2_valid;
    logic                   s2_last;

    always_comb begin
        s2_next = '0;
        for (int r = 0; r < ROWS; r++) s2_next = s2_next + S_BW'(s1_row[r]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_sum   <= '0;
        end else if (i_clr) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_sum   <= s2_next;
        end
    end

    // Stage 3: window accumulator
    logic signed [A_BW-1:0] acc;
    logic signed [A_BW-1:0] acc_sum;
    logic signed [A_BW-1:0] s2_ext;

    assign s2_ext = A_BW'(s2_sum);

`ifdef TILE_ACC_SAT_EN
    logic signed [A_BW:0] add_full;
    logic                 clamp;

    always_comb begin
        add_full = (A_BW+1)'(acc) + (A_BW+1)'(s2_ext);
        clamp    = add_full[A_BW] != add_full[A_BW-1];
        if (!clamp)              acc_sum = add_full[A_BW-1:0];
        else if (add_full[A_BW]) acc_sum = {1'b1, {(A_BW-1){1'b0}}};
        else                     acc_sum = {1'b0, {(A_BW-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     o_overflow <= 1'b0;
        else if (!i_clr && !stall && s2_valid && clamp) o_overflow <= 1'b1;
    end
`else
    assign acc_sum    = acc + s2_ext;
    assign o_overflow = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            os_acc_kernel <= '0;
            o_acc_valid   <= 1'b0;
        end else if (i_clr) begin
            acc           <= '0;
            os_acc_kernel <= '0;
            o_acc_valid   <= 1'b0;
        end else if (!stall) begin
            if (s2_valid && s2_last) begin
                os_acc_kernel <= acc_sum;
                o_acc_valid   <= 1'b1;
                acc           <= '0;
            end else begin
                // Unstalled means the held result (if any) was consumed this cycle.
                o_acc_valid <= 1'b0;
                if (s2_valid) acc <= acc_sum;
            end
        end
    end

    accum_state_t state;
    accum_state_t state_nxt;

    always_comb begin
        state_nxt = state;
        if (stall)                  state_nxt = ACCUM_HOLD;
        else if (s2_valid)          state_nxt = s2_last ? ACCUM_IDLE : ACCUM_RUN;
        else if (state == ACCUM_HOLD) state_nxt = ACCUM_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     state <= ACCUM_IDLE;
        else if (i_clr) state <= ACCUM_IDLE;
        else            state <= state_nxt;
    end
endmodule

// File: tb/tb_tile_kernel_acc.sv
// Self-checking bench for tile_kernel_acc: directed scenarios plus randomized windows
// scored against a window-level arithmetic model (wrap or saturate per TILE_ACC_SAT_EN).
module tb_tile_kernel_acc;
    localparam int M_BW = 16;
    localparam int ROWS = 5;
    localparam int COLS = 5;
    localparam int A_BW = 24;
    localparam int NP   = ROWS * COLS;

    localparam longint A_MAX = (longint'(1) << (A_BW - 1)) - 1;
    localparam longint A_MIN = -(longint'(1) << (A_BW - 1));
    localparam longint A_MOD = longint'(1) << A_BW;

    logic                     clk;
    logic                     rst_n;
    logic                     mul_valid;
    logic [M_BW*NP-1:0]       mul_result;
    logic                     last;
    logic                     clr;
    logic                     o_ready;
    logic                     o_acc_valid;
    logic                     acc_ready;
    logic signed [A_BW-1:0]   os_acc_kernel;
    logic                     o_overflow;

    tile_kernel_acc #(
        .M_BW (M_BW),
        .ROWS (ROWS),
        .COLS (COLS),
        .A_BW (A_BW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_mul_valid   (mul_valid),
        .i_mul_result  (mul_result),
        .i_last        (last),
        .i_clr         (clr),
        .o_ready       (o_ready),
        .o_acc_valid   (o_acc_valid),
        .i_acc_ready   (acc_ready),
        .os_acc_kernel (os_acc_kernel),
        .o_overflow    (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint val;
        bit     ovf;
    } exp_t;

    exp_t   exp_q[$];
    int     prod[NP];
    longint win;
    bit     ovf_m;
    bit     accepted;
    bit     rand_ready;
    int     checks;
    int     errors;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < NP; i++) mul_result[M_BW*i +: M_BW] = M_BW'(prod[i]);
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < NP; i++) prod[i] = v;
        pack();
    endtask

    task automatic set_rand();
        for (int i = 0; i < NP; i++) begin
            logic [M_BW-1:0] t;
            t = M_BW'($urandom);
            prod[i] = int'($signed(t));
        end
        pack();
    endtask

    task automatic model_reset();
        exp_q.delete();
        win   = 0;
        ovf_m = 1'b0;
    endtask

    // Window-level model: each accepted beat adds the sum of its products.
    task automatic model_beat(input bit is_last);
        longint s;
        s = 0;
        for (int i = 0; i < NP; i++) s += prod[i];
        win += s;
`ifdef TILE_ACC_SAT_EN
        if (win > A_MAX) begin
            win   = A_MAX;
            ovf_m = 1'b1;
        end else if (win < A_MIN) begin
            win   = A_MIN;
            ovf_m = 1'b1;
        end
`else
        win = ((win - A_MIN) % A_MOD + A_MOD) % A_MOD + A_MIN;
`endif
        if (is_last) begin
            exp_q.push_back('{val: win, ovf: ovf_m});
            win = 0;
        end
    endtask

    // One clock: observe handshakes mid-cycle, then advance to 1 time unit past the edge.
    task automatic tick();
        exp_t r;
        if (rand_ready) acc_ready = ($urandom_range(0, 3) != 0);
        #1;
        accepted = 1'b0;
        if (clr) begin
            exp_q.delete();
            win = 0;
        end else begin
            if (mul_valid && o_ready) begin
                model_beat(last);
                accepted = 1'b1;
            end
            if (o_acc_valid && acc_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_result", o_acc_valid, 0);
                end else begin
                    r = exp_q.pop_front();
                    check("result", os_acc_kernel, r.val);
                    check("result_ovf", o_overflow, r.ovf);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input bit is_last);
        mul_valid = 1'b1;
        last      = is_last;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (accepted) break;
        end
        check("beat_accepted", accepted, 1);
        mul_valid = 1'b0;
        last      = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) tick();
        check("drain", exp_q.size(), 0);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        rand_ready = 1'b0;
        rst_n      = 1'b0;
        mul_valid  = 1'b0;
        last       = 1'b0;
        clr        = 1'b0;
        acc_ready  = 1'b1;
        set_all(0);
        model_reset();

        // Reset state
        #3;
        check("rst_valid", o_acc_valid, 0);
        check("rst_kernel", os_acc_kernel, 0);
        check("rst_ovf", o_overflow, 0);
        check("rst_ready", o_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single-beat window of ones; result appears 3 cycles after acceptance
        set_all(1);
        send_beat(1'b1);
        check("lat_c1", o_acc_valid, 0);
        tick();
        check("lat_c2", o_acc_valid, 0);
        tick();
        check("lat_c3", o_acc_valid, 1);
        check("lat_val", os_acc_kernel, 25);
        drain();

        // Three beats of -2 then a fresh single-beat window
        set_all(-2);
        send_beat(1'b0);
        send_beat(1'b0);
        send_beat(1'b1);
        set_all(1);
        send_beat(1'b1);
        drain();

        // Back-pressure: result held, pipeline frozen, later beat waits
        acc_ready = 1'b0;
        set_all(3);
        send_beat(1'b1);
        set_all(-1);
        send_beat(1'b0);
        set_all(2);
        send_beat(1'b1);
        set_all(5);
        mul_valid = 1'b1;
        last      = 1'b1;
        for (int n = 0; n < 4; n++) begin
            check("stall_ready", o_ready, 0);
            check("stall_valid", o_acc_valid, 1);
            check("stall_hold", os_acc_kernel, 75);
            tick();
        end
        acc_ready = 1'b1;
        send_beat(1'b1);
        drain();

        // Flush mid-window, then a beat presented together with i_clr is dropped
        set_all(7);
        send_beat(1'b0);
        send_beat(1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int n = 0; n < 5; n++) begin
            check("clr_no_out", o_acc_valid, 0);
            tick();
        end
        set_all(1);
        mul_valid = 1'b1;
        last      = 1'b1;
        clr       = 1'b1;
        tick();
        clr       = 1'b0;
        mul_valid = 1'b0;
        last      = 1'b0;
        for (int n = 0; n < 4; n++) begin
            check("clr_drop", o_acc_valid, 0);
            tick();
        end
        send_beat(1'b1);
        drain();

        // Randomized windows with random gaps, stray i_last and random back-pressure
        rand_ready = 1'b1;
        for (int w = 0; w < 30; w++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                set_rand();
                if ($urandom_range(0, 2) == 0) begin
                    last = 1'($urandom);
                    tick();
                    last = 1'b0;
                end
                send_beat(b == len - 1);
            end
        end
        rand_ready = 1'b0;
        acc_ready  = 1'b1;
        drain();

        // Accumulator range: eleven beats of 32767 exceed the A_BW range
        set_all(32767);
        for (int b = 0; b < 10; b++) send_beat(1'b0);
        send_beat(1'b1);
        drain();
        check("ovf_after_range", o_overflow, ovf_m);
        set_all(1);
        send_beat(1'b1);
        drain();
        check("ovf_sticky", o_overflow, ovf_m);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("ovf_after_clr", o_overflow, ovf_m);

        // Reset mid-window with a result held and a partial window in flight
        acc_ready = 1'b0;
        set_all(4);
        send_beat(1'b0);
        set_all(2);
        send_beat(1'b1);
        set_all(3);
        send_beat(1'b0);
        send_beat(1'b0);
        check("pre_rst_valid", o_acc_valid, 1);
        check("pre_rst_val", os_acc_kernel, 150);
        rst_n = 1'b0;
        #2;
        check("mid_rst_valid", o_acc_valid, 0);
        check("mid_rst_kernel", os_acc_kernel, 0);
        check("mid_rst_ovf", o_overflow, 0);
        check("mid_rst_ready", o_ready, 1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        acc_ready = 1'b1;
        set_all(1);
        send_beat(1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
